// File: rtl/simd_pkg.sv
// Shared types and helpers for the SIMD dispatch controller and its lane trackers.
package simd_pkg;

    localparam int DEF_LANES   = 4;
    localparam int DEF_RS_SIZE = 4;
    // Tag width stored in every slot entry; the controller's TAG_W must match it.
    localparam int SLOT_TAG_W  = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_OR  = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4
    } opcode_e;

    typedef struct packed {
        logic                  waiting;
        logic                  pending;
        logic                  eligible;
        logic [SLOT_TAG_W-1:0] tag;
    } slot_state_t;

    // Lane reached by stepping 'offset' lanes from 'base', wrapping at 'lanes'.
    function automatic int unsigned LANE_IDX(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned lanes);
        return (base + offset) % lanes;
    endfunction

endpackage

// File: rtl/simd_lane_tracker.sv
// Per-lane bookkeeping: credits, RS tail pointer, slot table, tag wakeup and mark picker.
module simd_lane_tracker
    import simd_pkg::*;
#(
    parameter  int RS_SIZE = DEF_RS_SIZE,
    parameter  int TAG_W   = SLOT_TAG_W,
    localparam int IDX_W   = $clog2(RS_SIZE),
    localparam int CRED_W  = $clog2(RS_SIZE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             wr_pending,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             issue_now,
    input  logic             wake_valid,
    input  logic [TAG_W-1:0] wake_tag,
    input  logic             lane_done,
    output logic             credit_nz,
    output logic             mark_valid,
    output logic [IDX_W-1:0] mark_idx,
    output logic             done_err
);

    slot_state_t       slot_reg  [RS_SIZE];
    slot_state_t       slot_next [RS_SIZE];
    logic [CRED_W-1:0] credit_reg;
    logic [IDX_W-1:0]  tail_reg;
    logic [IDX_W-1:0]  issue_slot_reg;
    logic              credit_full;
    logic              done_inc;

    assign credit_full = (credit_reg == CRED_W'(RS_SIZE));
    assign credit_nz   = (credit_reg != '0);
    assign done_err    = lane_done && credit_full;
    assign done_inc    = lane_done && !credit_full;

    // Lowest-index slot that is both pending and eligible; silent on the lane's issue cycle.
    always_comb begin
        mark_valid = 1'b0;
        mark_idx   = '0;
        if (!issue_now) begin
            for (int s = RS_SIZE - 1; s >= 0; s--) begin
                if (slot_reg[s].pending && slot_reg[s].eligible) begin
                    mark_valid = 1'b1;
                    mark_idx   = IDX_W'(s);
                end
            end
        end
    end

    // Slot updates: wakeup, mark retirement, eligibility after issue; a new write overrides.
    always_comb begin
        for (int s = 0; s < RS_SIZE; s++) begin
            slot_next[s] = slot_reg[s];
            if (slot_reg[s].waiting && wake_valid &&
                (slot_reg[s].tag == SLOT_TAG_W'(wake_tag))) begin
                slot_next[s].waiting = 1'b0;
                slot_next[s].pending = 1'b1;
            end
            if (mark_valid && (mark_idx == IDX_W'(s)))
                slot_next[s].pending = 1'b0;
            if (issue_now && (issue_slot_reg == IDX_W'(s)))
                slot_next[s].eligible = 1'b1;
            if (wr_en && (tail_reg == IDX_W'(s))) begin
                slot_next[s].waiting  = !wr_pending;
                slot_next[s].pending  = wr_pending;
                slot_next[s].eligible = 1'b0;
                slot_next[s].tag      = SLOT_TAG_W'(wr_tag);
            end
        end
    end

    // Credit, tail and slot-table state; issue and retire in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            credit_reg     <= CRED_W'(RS_SIZE);
            tail_reg       <= '0;
            issue_slot_reg <= '0;
            for (int s = 0; s < RS_SIZE; s++)
                slot_reg[s] <= '0;
        end else begin
            slot_reg <= slot_next;
            case ({wr_en, done_inc})
                2'b10:   credit_reg <= credit_reg - 1'b1;
                2'b01:   credit_reg <= credit_reg + 1'b1;
                default: credit_reg <= credit_reg;
            endcase
            if (wr_en) begin
                tail_reg       <= tail_reg + 1'b1;
                issue_slot_reg <= tail_reg;
            end
        end
    end

endmodule

// File: rtl/simd_dispatch_ctrl.sv
// Front-end scheduler: round-robin lane select, registered issue, per-lane mark-ready generation.
module simd_dispatch_ctrl
    import simd_pkg::*;
#(
    parameter  int LANES   = DEF_LANES,
    parameter  int RS_SIZE = DEF_RS_SIZE,
    parameter  int TAG_W   = SLOT_TAG_W,
    localparam int IDX_W   = $clog2(RS_SIZE),
    localparam int PTR_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_A,
    input  logic [7:0]             in_B,
    input  logic [2:0]             in_opcode,
    input  logic                   in_dep,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic                   wake_valid,
    input  logic [TAG_W-1:0]       wake_tag,
    input  logic [LANES-1:0]       lane_done,
    output logic [LANES-1:0]       instr_valid,
    output logic [7:0]             A,
    output logic [7:0]             B,
    output logic [2:0]             opcode,
    output logic [LANES-1:0]       mark_ready_valid,
    output logic [LANES*IDX_W-1:0] mark_ready_idx,
    output logic                   err
);

    logic [LANES-1:0] credit_nz;
    logic [LANES-1:0] done_err;
    logic [PTR_W-1:0] rr_ptr_reg;
    logic [PTR_W-1:0] sel;
    logic             accept;
    logic             wr_pending;
    logic [LANES-1:0] instr_valid_reg;
    logic [7:0]       a_reg;
    logic [7:0]       b_reg;
    opcode_e          opcode_reg;
    logic             err_reg;

    assign in_ready   = |credit_nz;
    assign accept     = in_valid && in_ready;
    // A producer broadcast in the accept cycle already satisfies the dependency.
    assign wr_pending = !in_dep || (wake_valid && (wake_tag == in_tag));

    // Round-robin pick: first lane at or after rr_ptr with a free credit.
    always_comb begin
        int unsigned cand;
        sel  = '0;
        cand = 0;
        for (int i = LANES - 1; i >= 0; i--) begin
            cand = LANE_IDX(int'(rr_ptr_reg), i, LANES);
            if (credit_nz[cand])
                sel = PTR_W'(cand);
        end
    end

    // Issue registers, round-robin pointer and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg      <= '0;
            instr_valid_reg <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            opcode_reg      <= OP_ADD;
            err_reg         <= 1'b0;
        end else begin
            instr_valid_reg <= accept ? (LANES'(1) << sel) : '0;
            if (accept) begin
                rr_ptr_reg <= PTR_W'(LANE_IDX(int'(sel), 1, LANES));
                a_reg      <= in_A;
                b_reg      <= in_B;
                opcode_reg <= opcode_e'(in_opcode);
            end
            err_reg <= err_reg | (|done_err);
        end
    end

    assign instr_valid = instr_valid_reg;
    assign A           = a_reg;
    assign B           = b_reg;
    assign opcode      = opcode_reg;
    assign err         = err_reg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic             lane_mark_valid;
            logic [IDX_W-1:0] lane_mark_idx;

            simd_lane_tracker #(
                .RS_SIZE (RS_SIZE),
                .TAG_W   (TAG_W)
            ) u_tracker (
                .clk        (clk),
                .reset      (reset),
                .wr_en      (accept && (sel == PTR_W'(gi))),
                .wr_pending (wr_pending),
                .wr_tag     (in_tag),
                .issue_now  (instr_valid_reg[gi]),
                .wake_valid (wake_valid),
                .wake_tag   (wake_tag),
                .lane_done  (lane_done[gi]),
                .credit_nz  (credit_nz[gi]),
                .mark_valid (lane_mark_valid),
                .mark_idx   (lane_mark_idx),
                .done_err   (done_err[gi])
            );

            assign mark_ready_valid[gi]                 = lane_mark_valid;
            assign mark_ready_idx[gi*IDX_W +: IDX_W]    = lane_mark_idx;
        end
    endgenerate

endmodule

// File: tb/tb_simd_dispatch_ctrl.sv
// Self-checking bench for simd_dispatch_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural scheduler model.
module tb_simd_dispatch_ctrl;

    localparam int L  = 4;
    localparam int R  = 4;
    localparam int TW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_A, in_B;
    logic [2:0]      in_opcode;
    logic            in_dep;
    logic [TW-1:0]   in_tag;
    logic            wake_valid;
    logic [TW-1:0]   wake_tag;
    logic [L-1:0]    lane_done;
    logic [L-1:0]    instr_valid;
    logic [7:0]      A, B;
    logic [2:0]      opcode;
    logic [L-1:0]    mark_ready_valid;
    logic [L*IW-1:0] mark_ready_idx;
    logic            err;

    always #5 clk = ~clk;

    simd_dispatch_ctrl #(.LANES(L), .RS_SIZE(R), .TAG_W(TW)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_A             (in_A),
        .in_B             (in_B),
        .in_opcode        (in_opcode),
        .in_dep           (in_dep),
        .in_tag           (in_tag),
        .wake_valid       (wake_valid),
        .wake_tag         (wake_tag),
        .lane_done        (lane_done),
        .instr_valid      (instr_valid),
        .A                (A),
        .B                (B),
        .opcode           (opcode),
        .mark_ready_valid (mark_ready_valid),
        .mark_ready_idx   (mark_ready_idx),
        .err              (err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: how many free RS entries each lane has, and what each entry waits on.
    int         m_credit [L];
    int         m_tail   [L];
    int         m_rr;
    bit         m_wait   [L][R];
    bit         m_pend   [L][R];
    bit         m_elig   [L][R];
    int         m_tagv   [L][R];
    bit [L-1:0] m_iv;
    int         m_islot  [L];
    logic [7:0] m_a, m_b;
    logic [2:0] m_op;
    bit         m_err;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < L; l++) begin
            m_credit[l] = R;
            m_tail[l]   = 0;
            m_islot[l]  = 0;
            for (int s = 0; s < R; s++) begin
                m_wait[l][s] = 0; m_pend[l][s] = 0; m_elig[l][s] = 0; m_tagv[l][s] = 0;
            end
        end
        m_rr = 0; m_iv = '0; m_a = '0; m_b = '0; m_op = '0; m_err = 0;
    endtask

    function automatic bit model_ready();
        for (int l = 0; l < L; l++)
            if (m_credit[l] > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Expected mark for a lane: lowest slot that is pending and eligible, none on issue cycles.
    task automatic model_mark(input int l, output bit v, output int idx);
        v = 0; idx = 0;
        if (!m_iv[l]) begin
            for (int s = 0; s < R; s++)
                if (!v && m_pend[l][s] && m_elig[l][s]) begin v = 1; idx = s; end
        end
    endtask

    task automatic check_outputs();
        bit mv; int mi;
        chk("in_ready", in_ready, model_ready());
        chk("instr_valid", instr_valid, m_iv);
        chk("A", A, m_a);
        chk("B", B, m_b);
        chk("opcode", opcode, m_op);
        chk("err", err, m_err);
        for (int l = 0; l < L; l++) begin
            model_mark(l, mv, mi);
            chk($sformatf("mark_valid[%0d]", l), mark_ready_valid[l], mv);
            if (mv) chk($sformatf("mark_idx[%0d]", l), mark_ready_idx[l*IW +: IW], mi);
        end
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        bit mv [L]; int mi [L];
        bit acc; int sel; bit p;
        if (reset) begin model_reset(); return; end
        for (int l = 0; l < L; l++) model_mark(l, mv[l], mi[l]);
        acc = in_valid && model_ready();
        sel = -1;
        for (int i = 0; i < L; i++)
            if (sel < 0 && m_credit[(m_rr + i) % L] > 0) sel = (m_rr + i) % L;
        for (int l = 0; l < L; l++) begin
            for (int s = 0; s < R; s++) begin
                if (mv[l] && mi[l] == s) m_pend[l][s] = 0;
                if (m_wait[l][s] && wake_valid && m_tagv[l][s] == int'(wake_tag)) begin
                    m_wait[l][s] = 0; m_pend[l][s] = 1;
                end
                if (m_iv[l] && m_islot[l] == s) m_elig[l][s] = 1;
            end
            if (lane_done[l]) begin
                if (m_credit[l] == R) m_err = 1;
                else m_credit[l]++;
            end
        end
        m_iv = '0;
        if (acc) begin
            p = !in_dep || (wake_valid && wake_tag == in_tag);
            m_wait[sel][m_tail[sel]] = !p;
            m_pend[sel][m_tail[sel]] = p;
            m_elig[sel][m_tail[sel]] = 0;
            m_tagv[sel][m_tail[sel]] = int'(in_tag);
            m_islot[sel] = m_tail[sel];
            m_tail[sel]  = (m_tail[sel] + 1) % R;
            m_credit[sel]--;
            m_rr = (sel + 1) % L;
            m_iv[sel] = 1'b1;
            m_a = in_A; m_b = in_B; m_op = in_opcode;
        end
    endtask

    task automatic tick();
        check_outputs();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_A = '0; in_B = '0; in_opcode = '0; in_dep = 0; in_tag = '0;
        wake_valid = 0; wake_tag = '0; lane_done = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1; tick();
        reset = 0;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input bit dep, input logic [TW-1:0] tag);
        in_valid = 1; in_A = a; in_B = b; in_opcode = op; in_dep = dep; in_tag = tag;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: single independent ADD, issue at T+1, mark at T+2
        push(8'd5, 8'd3, 3'd0, 0, '0); tick();
        idle_inputs();
        chk("t1_issue", instr_valid, 4'b0001);
        chk("t1_A", A, 8'd5);
        tick();
        chk("t1_mark", mark_ready_valid, 4'b0001);
        tick(); tick();

        // 2: five back-to-back accepts rotate 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(8'(i), 8'(i + 10), 3'(i), 0, '0); tick();
        end
        idle_inputs();
        chk("t2_fifth_lane0", instr_valid, 4'b0001);
        for (int i = 0; i < 3; i++) tick();

        // 3: fill all sixteen entries, then free one on lane 2
        do_reset();
        for (int i = 0; i < L * R; i++) begin
            push(8'($urandom), 8'($urandom), 3'($urandom_range(0, 4)), 0, '0); tick();
        end
        idle_inputs();
        chk("t3_full", in_ready, 1'b0);
        lane_done = 4'b0100; tick();
        idle_inputs();
        chk("t3_ready_again", in_ready, 1'b1);
        push(8'd1, 8'd2, 3'd1, 0, '0); tick();
        idle_inputs();
        chk("t3_lane2", instr_valid, 4'b0100);
        tick(); tick();

        // 4: dependent entry in lane1 slot0 woken only by its own tag
        do_reset();
        push(8'd7, 8'd8, 3'd2, 0, '0); tick();
        push(8'd9, 8'd4, 3'd3, 1, 4'd7); tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        wake_valid = 1; wake_tag = 4'd3; tick();
        idle_inputs();
        chk("t4_wrong_tag", mark_ready_valid[1], 1'b0);
        wake_valid = 1; wake_tag = 4'd7; tick();
        idle_inputs();
        chk("t4_woken", mark_ready_valid[1], 1'b1);
        chk("t4_idx", mark_ready_idx[3:2], 2'd0);
        tick();

        // 5: wakeup in the accept cycle counts as independent
        do_reset();
        push(8'd3, 8'd3, 3'd4, 1, 4'd9); wake_valid = 1; wake_tag = 4'd9; tick();
        idle_inputs(); tick();
        chk("t5_mark", mark_ready_valid, 4'b0001);
        tick();

        // 6: reset with marks pending, then a retire at full credit
        do_reset();
        push(8'd1, 8'd1, 3'd0, 0, '0); tick();
        push(8'd2, 8'd2, 3'd0, 0, '0); tick();
        idle_inputs();
        reset = 1; tick();
        reset = 0;
        chk("t6_iv", instr_valid, '0);
        chk("t6_mark", mark_ready_valid, '0);
        chk("t6_ready", in_ready, 1'b1);
        chk("t6_err0", err, 1'b0);
        lane_done = 4'b0001; tick();
        idle_inputs();
        chk("t6_err1", err, 1'b1);
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            in_A       = 8'($urandom);
            in_B       = 8'($urandom);
            in_opcode  = 3'($urandom_range(0, 4));
            in_dep     = 1'($urandom);
            in_tag     = TW'($urandom_range(0, 5));
            wake_valid = 1'($urandom);
            wake_tag   = TW'($urandom_range(0, 5));
            for (int l = 0; l < L; l++) lane_done[l] = ($urandom_range(0, 4) == 0);
            reset      = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 0;
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
